// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the initiator FSM state type.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_t;

endpackage

// File: rtl/apb_req_initiator.sv
// APB4 initiator bridge.
// Takes one single-beat request at a time from a valid/ready request channel, runs it as an
// APB4 SETUP/ACCESS transfer, and returns read data plus error status on a valid/ready
// response channel. An ACCESS-phase watchdog forces an error response if the slave never
// raises pready (TIMEOUT_CYCLES = 0 disables it).
//
// Ports:
//   clock, resetn            clock and synchronous active-low reset
//   req_*                    request channel (valid/ready, addr, write, wdata, wstrb, prot)
//   resp_*                   response channel (valid/ready, rdata, err)
//   out_p* (outputs)         APB address, write data, psel, penable, pwrite, pprot, pstrb
//   out_pready/pslverr/prdata APB slave response inputs
module apb_req_initiator
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clock,
  input  logic                  resetn,
  // Request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [APB_ADDR_W-1:0] req_addr,
  input  logic                  req_write,
  input  logic [APB_DATA_W-1:0] req_wdata,
  input  logic [APB_STRB_W-1:0] req_wstrb,
  input  logic [2:0]            req_prot,
  // Response channel
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [APB_DATA_W-1:0] resp_rdata,
  output logic                  resp_err,
  // APB initiator side
  output logic [APB_ADDR_W-1:0] out_paddr,
  output logic [APB_DATA_W-1:0] out_pwdata,
  output logic                  out_psel,
  output logic                  out_penable,
  output logic                  out_pwrite,
  output logic [2:0]            out_pprot,
  output logic [APB_STRB_W-1:0] out_pstrb,
  input  logic                  out_pready,
  input  logic                  out_pslverr,
  input  logic [APB_DATA_W-1:0] out_prdata
);

  // A zero timeout still needs a legal (1-bit) counter even though it is never compared.
  localparam int unsigned CntW    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          WdogEn  = (TIMEOUT_CYCLES != 0);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [CntW-1:0] CntLast = WdogEn ? CntW'(TIMEOUT_CYCLES - 1) : '0;

  apb_state_t            r_state;
  apb_state_t            w_state_next;

  logic [APB_ADDR_W-1:0] r_paddr;
  logic [APB_DATA_W-1:0] r_pwdata;
  logic                  r_pwrite;
  logic [APB_STRB_W-1:0] r_pstrb;
  logic [2:0]            r_pprot;

  logic [CntW-1:0]       r_cnt;
  logic [CntW-1:0]       w_cnt_next;

  logic [APB_DATA_W-1:0] r_rdata;
  logic [APB_DATA_W-1:0] w_rdata_next;
  logic                  r_err;
  logic                  w_err_next;

  logic                  w_accept;
  logic                  w_timeout;

  assign w_timeout = WdogEn && (r_cnt == CntLast);

  // Next-state, watchdog and response-capture logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rdata_next = r_rdata;
    w_err_next   = r_err;
    w_accept     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_SETUP;
        end
      end

      ST_SETUP: begin
        // Counter clears on the way into ACCESS; pready is not looked at here.
        w_cnt_next   = '0;
        w_state_next = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (r_cnt != CntMax) begin
          w_cnt_next = r_cnt + 1'b1;
        end
        // pready takes priority over a watchdog expiry in the same cycle.
        if (out_pready) begin
          w_rdata_next = r_pwrite ? '0 : out_prdata;
          w_err_next   = out_pslverr;
          w_state_next = ST_RESP;
        end else if (w_timeout) begin
          w_rdata_next = '0;
          w_err_next   = 1'b1;
          w_state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_pstrb  <= '0;
      r_pprot  <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rdata <= w_rdata_next;
      r_err   <= w_err_next;
      if (w_accept) begin
        r_paddr  <= req_addr;
        r_pwdata <= req_wdata;
        r_pwrite <= req_write;
        r_pstrb  <= req_write ? req_wstrb : '0;
        r_pprot  <= req_prot;
      end
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = (r_state == ST_RESP);
  assign out_psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign out_penable = (r_state == ST_ACCESS);
  assign out_paddr   = r_paddr;
  assign out_pwdata  = r_pwdata;
  assign out_pwrite  = r_pwrite;
  assign out_pstrb   = r_pstrb;
  assign out_pprot   = r_pprot;
  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;

endmodule

// File: tb/tb_apb_req_initiator.sv
// Self-checking bench for apb_req_initiator (watchdog set to 8 cycles).
module tb_apb_req_initiator;

  localparam int unsigned TO = 8;

  logic        clock;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_prot;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] out_paddr;
  logic [31:0] out_pwdata;
  logic        out_psel;
  logic        out_penable;
  logic        out_pwrite;
  logic [2:0]  out_pprot;
  logic [3:0]  out_pstrb;
  logic        out_pready;
  logic        out_pslverr;
  logic [31:0] out_prdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave model configuration
  int          cfg_waits;
  bit          cfg_never;
  bit          cfg_err;
  bit          cfg_noise;
  logic [31:0] cfg_rdata;
  int          acc_q;

  apb_req_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .req_prot   (req_prot),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .out_paddr  (out_paddr),
    .out_pwdata (out_pwdata),
    .out_psel   (out_psel),
    .out_penable(out_penable),
    .out_pwrite (out_pwrite),
    .out_pprot  (out_pprot),
    .out_pstrb  (out_pstrb),
    .out_pready (out_pready),
    .out_pslverr(out_pslverr),
    .out_prdata (out_prdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave: raises pready after cfg_waits ACCESS cycles; optionally also during SETUP (noise).
  always @(posedge clock) acc_q <= (out_psel && out_penable && !out_pready) ? acc_q + 1 : 0;
  assign out_pready  = (out_psel && !out_penable && cfg_noise) ||
                       (out_psel && out_penable && !cfg_never && (acc_q == cfg_waits));
  assign out_pslverr = cfg_err;
  assign out_prdata  = cfg_rdata;

  // Reference: what the response and timing must be for a given request and slave behaviour.
  function automatic void model(input bit w, input logic [3:0] ws, input int waits,
                                input bit never, input bit serr, input logic [31:0] rd,
                                output int e_lat, output int e_acc, output logic [31:0] e_rdata,
                                output logic e_err, output logic [3:0] e_strb);
    e_strb = w ? ws : 4'h0;
    if (never || waits >= int'(TO)) begin
      e_acc = TO; e_lat = 2 + TO; e_rdata = 32'h0; e_err = 1'b1;
    end else begin
      e_acc = waits + 1; e_lat = 3 + waits; e_rdata = w ? 32'h0 : rd; e_err = serr;
    end
  endfunction

  // Drives one request, plays the slave, observes the bus and response. No judgement here.
  task automatic run_txn(input logic [31:0] a, input bit w, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [2:0] pr, input int waits,
                         input bit never, input bit serr, input logic [31:0] rd, input int rdly,
                         output int lat, output int acc, output bit stable, output logic [1:0] su,
                         output logic [31:0] s_addr, output logic [31:0] s_wdata,
                         output logic s_write, output logic [3:0] s_strb, output logic [2:0] s_prot,
                         output logic [31:0] s_rdata, output logic s_err,
                         output bit hold_ok, output bit done_ok);
    cfg_waits = waits; cfg_never = never; cfg_err = serr; cfg_rdata = rd;
    req_addr = a; req_write = w; req_wdata = wd; req_wstrb = ws; req_prot = pr; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_addr = ~a; req_wdata = ~wd; req_wstrb = ~ws; req_prot = ~pr; req_write = ~w;
    lat = 1; acc = 0; stable = 1'b1; hold_ok = 1'b1;
    su = {out_psel, out_penable};
    s_addr = out_paddr; s_wdata = out_pwdata; s_write = out_pwrite;
    s_strb = out_pstrb; s_prot = out_pprot;
    while (resp_valid !== 1'b1 && lat < 40) begin
      if (out_psel && out_penable) acc++;
      if (out_psel !== 1'b1 || req_ready !== 1'b0 || out_paddr !== s_addr ||
          out_pwdata !== s_wdata || out_pwrite !== s_write || out_pstrb !== s_strb ||
          out_pprot !== s_prot) stable = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    s_rdata = resp_rdata; s_err = resp_err;
    if (out_psel !== 1'b0 || out_penable !== 1'b0) hold_ok = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      @(posedge clock); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== s_rdata || resp_err !== s_err ||
          req_ready !== 1'b0 || out_psel !== 1'b0) hold_ok = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    done_ok = (resp_valid === 1'b0) && (req_ready === 1'b1) && (out_psel === 1'b0);
    cfg_noise = 1'b0;
  endtask

  // Observation / expectation holders shared by the scenario tasks (single process only).
  int lat, acc, e_lat, e_acc;
  bit stable, hold_ok, done_ok;
  logic [1:0]  su;
  logic [31:0] s_addr, s_wdata, s_rdata, e_rdata;
  logic        s_write, s_err, e_err;
  logic [3:0]  s_strb, e_strb;
  logic [2:0]  s_prot;

  task automatic test_reset();
    resetn = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    n_cmp++; if ({resp_valid, out_psel, out_penable, resp_err, out_pwrite} !== 5'b0) begin
      n_bad++; $display("FAIL rst_ctrl got %b want 00000", {resp_valid, out_psel, out_penable, resp_err, out_pwrite}); end
    n_cmp++; if ({out_paddr, out_pwdata, resp_rdata, out_pstrb, out_pprot} !== 103'b0) begin
      n_bad++; $display("FAIL rst_data got %h want 0", {out_paddr, out_pwdata, resp_rdata, out_pstrb, out_pprot}); end
    resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_read_basic();
    run_txn(32'hA000_0004, 1'b0, 32'h5555_AAAA, 4'hF, 3'd2, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 0,
            lat, acc, stable, su, s_addr, s_wdata, s_write, s_strb, s_prot, s_rdata, s_err,
            hold_ok, done_ok);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency got %0d want 3", lat); end
    n_cmp++; if (s_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_rdata got %h want deadbeef", s_rdata); end
    n_cmp++; if (s_err !== 1'b0) begin n_bad++; $display("FAIL rd_err got %b want 0", s_err); end
    n_cmp++; if (s_strb !== 4'h0) begin n_bad++; $display("FAIL rd_pstrb got %h want 0", s_strb); end
    n_cmp++; if (s_addr !== 32'hA000_0004) begin n_bad++; $display("FAIL rd_paddr got %h want a0000004", s_addr); end
    n_cmp++; if (su !== 2'b10) begin n_bad++; $display("FAIL rd_setup got %b want 10", su); end
    n_cmp++; if (done_ok !== 1'b1) begin n_bad++; $display("FAIL rd_back_idle got %b want 1", done_ok); end
  endtask

  task automatic test_write_waits();
    run_txn(32'h0000_1230, 1'b1, 32'h1234_5678, 4'b0110, 3'd5, 3, 1'b0, 1'b0, 32'hFFFF_FFFF, 0,
            lat, acc, stable, su, s_addr, s_wdata, s_write, s_strb, s_prot, s_rdata, s_err,
            hold_ok, done_ok);
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL wr_latency got %0d want 6", lat); end
    n_cmp++; if (acc !== 4) begin n_bad++; $display("FAIL wr_access_cycles got %0d want 4", acc); end
    n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL wr_stable got %b want 1", stable); end
    n_cmp++; if ({s_wdata, s_strb, s_write} !== {32'h1234_5678, 4'b0110, 1'b1}) begin
      n_bad++; $display("FAIL wr_bus got %h/%b/%b want 12345678/0110/1", s_wdata, s_strb, s_write); end
    n_cmp++; if (s_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rdata got %h want 0", s_rdata); end
  endtask

  task automatic test_slverr();
    run_txn(32'h4000_0008, 1'b0, 32'h0, 4'h0, 3'd0, 1, 1'b0, 1'b1, 32'hCAFE_F00D, 0,
            lat, acc, stable, su, s_addr, s_wdata, s_write, s_strb, s_prot, s_rdata, s_err,
            hold_ok, done_ok);
    n_cmp++; if (s_err !== 1'b1) begin n_bad++; $display("FAIL slverr_err got %b want 1", s_err); end
    n_cmp++; if (done_ok !== 1'b1) begin n_bad++; $display("FAIL slverr_idle got %b want 1", done_ok); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL slverr_latency got %0d want 4", lat); end
  endtask

  task automatic test_timeout();
    cfg_err = 1'b0;
    run_txn(32'h8000_0000, 1'b0, 32'h0, 4'h0, 3'd1, 0, 1'b1, 1'b0, 32'h1357_9BDF, 0,
            lat, acc, stable, su, s_addr, s_wdata, s_write, s_strb, s_prot, s_rdata, s_err,
            hold_ok, done_ok);
    n_cmp++; if (acc !== int'(TO)) begin n_bad++; $display("FAIL to_access_cycles got %0d want %0d", acc, TO); end
    n_cmp++; if (lat !== int'(TO) + 2) begin n_bad++; $display("FAIL to_latency got %0d want %0d", lat, TO + 2); end
    n_cmp++; if ({s_err, s_rdata} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL to_resp got err=%b rdata=%h want err=1 rdata=0", s_err, s_rdata); end
    n_cmp++; if (hold_ok !== 1'b1) begin n_bad++; $display("FAIL to_psel_low got %b want 1", hold_ok); end
  endtask

  task automatic test_backpressure();
    run_txn(32'h2000_0010, 1'b0, 32'h0, 4'h0, 3'd3, 2, 1'b0, 1'b1, 32'h0BAD_CAFE, 5,
            lat, acc, stable, su, s_addr, s_wdata, s_write, s_strb, s_prot, s_rdata, s_err,
            hold_ok, done_ok);
    n_cmp++; if (hold_ok !== 1'b1) begin n_bad++; $display("FAIL bp_hold got %b want 1", hold_ok); end
    n_cmp++; if ({s_err, s_rdata} !== {1'b1, 32'h0BAD_CAFE}) begin
      n_bad++; $display("FAIL bp_resp got %b/%h want 1/0badcafe", s_err, s_rdata); end
    n_cmp++; if (done_ok !== 1'b1) begin n_bad++; $display("FAIL bp_release got %b want 1", done_ok); end
  endtask

  task automatic test_reset_mid();
    cfg_never = 1'b1; cfg_err = 1'b0;
    req_addr = 32'h3000_0000; req_write = 1'b1; req_wdata = 32'h1; req_wstrb = 4'hF;
    req_prot = 3'd0; req_valid = 1'b1;
    @(posedge clock); #1; req_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    n_cmp++; if ({out_psel, out_penable} !== 2'b11) begin
      n_bad++; $display("FAIL rm_in_access got %b want 11", {out_psel, out_penable}); end
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    n_cmp++; if ({out_psel, out_penable, resp_valid, req_ready} !== 4'b0001) begin
      n_bad++; $display("FAIL rm_after_reset got %b want 0001", {out_psel, out_penable, resp_valid, req_ready}); end
    repeat (TO + 2) begin
      @(posedge clock); #1;
    end
    n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin
      n_bad++; $display("FAIL rm_no_stale_resp got %b want 01", {resp_valid, req_ready}); end
    cfg_never = 1'b0;
  endtask

  // Back-to-back random transfers, each issued the cycle after the previous handshake.
  task automatic test_random();
    logic [31:0] a, wd, rd;
    logic [3:0]  ws;
    logic [2:0]  pr;
    bit w, never, serr;
    int waits, rdly;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; wd = $urandom; rd = $urandom;
      ws = 4'($urandom); pr = 3'($urandom); w = 1'($urandom);
      waits = $urandom_range(0, 9); never = ($urandom_range(0, 7) == 0);
      serr = 1'($urandom); rdly = $urandom_range(0, 3);
      cfg_noise = 1'($urandom);
      model(w, ws, waits, never, serr, rd, e_lat, e_acc, e_rdata, e_err, e_strb);
      run_txn(a, w, wd, ws, pr, waits, never, serr, rd, rdly,
              lat, acc, stable, su, s_addr, s_wdata, s_write, s_strb, s_prot, s_rdata, s_err,
              hold_ok, done_ok);
      n_cmp++; if (lat !== e_lat || acc !== e_acc) begin
        n_bad++; $display("FAIL rnd%0d_timing got lat=%0d acc=%0d want lat=%0d acc=%0d", i, lat, acc, e_lat, e_acc); end
      n_cmp++; if ({s_addr, s_wdata, s_write, s_strb, s_prot} !== {a, wd, w, e_strb, pr}) begin
        n_bad++; $display("FAIL rnd%0d_bus got %h %h %b %h %h want %h %h %b %h %h", i,
                          s_addr, s_wdata, s_write, s_strb, s_prot, a, wd, w, e_strb, pr); end
      n_cmp++; if ({s_err, s_rdata} !== {e_err, e_rdata}) begin
        n_bad++; $display("FAIL rnd%0d_resp got %b/%h want %b/%h", i, s_err, s_rdata, e_err, e_rdata); end
      n_cmp++; if ({stable, su, hold_ok, done_ok} !== 5'b11011) begin
        n_bad++; $display("FAIL rnd%0d_proto got %b want 11011", i, {stable, su, hold_ok, done_ok}); end
    end
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_write = 1'b0; req_wdata = '0; req_wstrb = '0; req_prot = '0;
    cfg_waits = 0; cfg_never = 1'b0; cfg_err = 1'b0; cfg_noise = 1'b0; cfg_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_read_basic();
    test_write_waits();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_req_initiator.md
# apb_req_initiator

APB initiator bridge: accepts single-beat memory requests on a valid/ready request channel and drives them as APB4 transfers toward slaves such as the SDRAM and peripheral APB targets. It returns read data and error status on a valid/ready response channel. A cycle-limited access watchdog guarantees a response even when a slave never raises `pready`. It sits between the core-side crossbar and the APB peripheral fabric, as the initiating end of the APB link.

## Interface
- `TIMEOUT_CYCLES`, 256: maximum ACCESS-phase cycles before abort; 0 disables the watchdog.
- `clock`  in  1  sole clock; all logic is posedge.
- `resetn`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bridge can accept a request.
- `req_addr`  in  32  byte address.
- `req_write`  in  1  1 = write.
- `req_wdata`  in  32  write data.
- `req_wstrb`  in  4  byte strobes; ignored for reads.
- `req_prot`  in  3  passed to `out_pprot`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  32  read data; 0 for writes and for timeouts.
- `resp_err`  out  1  slave `pslverr` or timeout.
- `out_paddr`, `out_pwdata`  out  32 each  APB address and write data.
- `out_psel`, `out_penable`, `out_pwrite`  out  1 each  APB control.
- `out_pprot`  out  3  APB protection.
- `out_pstrb`  out  4  APB strobes; forced to 0 on reads.
- `out_pready`, `out_pslverr`  in  1 each  APB slave response.
- `out_prdata`  in  32  APB read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, register addr, write, wdata, wstrb (masked to 0 for reads) and prot, then go to SETUP.
- SETUP: `psel` = 1, `penable` = 0. Go to ACCESS unconditionally. `out_pready` is ignored in this state.
- ACCESS: `psel` = 1, `penable` = 1. The watchdog counter increments each cycle.
  - `out_pready` = 1: capture `prdata` (reads only; writes capture 0) and `pslverr`, then go to RESP.
  - Otherwise, if `TIMEOUT_CYCLES` ≠ 0 and the counter reaches `TIMEOUT_CYCLES` − 1: set err = 1 and rdata = 0, then go to RESP.
  - If `pready` and timeout coincide, `pready` wins.
- RESP:
  - `psel` = `penable` = 0.
  - `resp_valid` = 1; held with stable data until `resp_ready`, then go to IDLE.
- The APB address, data, control and strobe outputs are driven from registers and stay stable from SETUP through the end of ACCESS.
- Only one transaction is ever outstanding. There is no pipelining.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`. It clears on entry to ACCESS and saturates.

## Timing
- Reset (`resetn` = 0 at an edge): state becomes IDLE on that edge.
  - All outputs go to 0 except `req_ready`, which becomes 1.
  - This applies mid-transfer too: `psel` drops on the reset edge, and any pending response is discarded.
- Minimum latency: request accepted at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2 (`pready` = 1) → `resp_valid` in cycle 3.
- Each extra wait state adds one cycle.
- Next-request acceptance:
  - Earliest is the cycle after the `resp_valid`·`resp_ready` handshake.
  - `req_ready` is low from SETUP through RESP.
- A timed-out transfer occupies exactly `TIMEOUT_CYCLES` ACCESS cycles.

## Structure
- Shared `apb_pkg` holds:
  - the `apb_state_t` enum {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP};
  - the width constants APB_ADDR_W = 32, APB_DATA_W = 32, APB_STRB_W = 4.
- Single module with no sub-modules. The watchdog is an inline counter.

## Test plan
- Read at 0xA000_0004; slave returns `pready` = 1 in the first ACCESS cycle with `prdata` = 0xDEAD_BEEF → `resp_valid` in cycle 3, `resp_rdata` = 0xDEAD_BEEF, `resp_err` = 0, `out_pstrb` = 0.
- Write 0x1234_5678 with `wstrb` = 0b0110 and 3 wait states → `pwdata`, `paddr` and `pstrb` stable across SETUP plus 4 ACCESS cycles; `resp_rdata` = 0, `resp_valid` in cycle 6.
- Slave asserts `pslverr` = 1 together with `pready` → `resp_err` = 1; the bridge returns to IDLE afterwards.
- `TIMEOUT_CYCLES` = 8 and `pready` never rises → exactly 8 ACCESS cycles, then `psel` = 0, `resp_err` = 1, `resp_rdata` = 0.
- `resp_ready` held low for 5 cycles → `resp_valid`, `resp_rdata` and `resp_err` stay stable and `req_ready` stays 0. Also: `resetn` pulsed low during ACCESS → next cycle `psel` = `penable` = 0, `resp_valid` = 0, `req_ready` = 1.
